// File: rtl/divider64_seq.sv
// ----------------------------------------------------------------------------
// divider64_seq
// Multi-cycle integer divider for the RV64M DIV/DIVU/REM/REMU path.
// Restoring radix-2 division: one trial subtraction per clock, so a normal
// operation takes WIDTH iterations plus one sign-fix cycle. Quotient and
// remainder are produced together. Divide-by-zero and signed overflow follow
// RISC-V semantics and bypass the iteration loop.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      request, sampled only while idle
//   is_signed  in   1      1 = two's-complement operands, 0 = unsigned
//   a          in   WIDTH  dividend, sampled with start
//   b          in   WIDTH  divisor, sampled with start
//   busy       out  1      operation in progress; start ignored while high
//   done       out  1      one-cycle pulse, q/r/div0 valid
//   q          out  WIDTH  quotient, held until the next done
//   r          out  WIDTH  remainder, held until the next done
//   div0       out  1      divisor was zero, valid with done and held
// ----------------------------------------------------------------------------
module divider64_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Two's-complement negation; the most negative value maps onto its own
    // bit pattern, which read as unsigned is exactly its magnitude.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] value);
        negate = ~value + ONE_W;
    endfunction

    // Magnitude of a value when it is to be read as signed, else the raw value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                   input logic             as_signed);
        if (as_signed && value[WIDTH-1]) begin
            magnitude = negate(value);
        end else begin
            magnitude = value;
        end
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] rem_r, rem_s;        // partial remainder
    logic [WIDTH-1:0] quo_r, quo_s;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_r, dvs_s;        // divisor magnitude
    logic [CW-1:0]    cnt_r, cnt_s;        // iterations remaining
    logic             neg_q_r, neg_q_s;
    logic             neg_r_r, neg_r_s;
    logic             div0_case_r, div0_case_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [WIDTH-1:0] q_r, q_s;
    logic [WIDTH-1:0] r_r, r_s;
    logic             div0_r, div0_s;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;

    // Trial subtraction for the current iteration: {rem,quo} shifted left by
    // one, then the divisor magnitude subtracted in WIDTH+1 bits so the sign
    // bit tells whether the subtraction fits.
    always_comb begin
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dvs_r};
    end

    // Next-state and datapath update for the IDLE -> CALC -> FIX sequence.
    always_comb begin
        state_s     = state_r;
        rem_s       = rem_r;
        quo_s       = quo_r;
        dvs_s       = dvs_r;
        cnt_s       = cnt_r;
        neg_q_s     = neg_q_r;
        neg_r_s     = neg_r_r;
        div0_case_s = div0_case_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        q_s         = q_r;
        r_s         = r_r;
        div0_s      = div0_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    busy_s      = 1'b1;
                    dvs_s       = magnitude(b, is_signed);
                    cnt_s       = CNT_INIT;
                    div0_case_s = (b == ZERO_W);
                    if (b == ZERO_W) begin
                        // Final values loaded directly; FIX passes them through.
                        quo_s   = ONES_W;
                        rem_s   = a;
                        neg_q_s = 1'b0;
                        neg_r_s = 1'b0;
                        state_s = ST_FIX;
                    end else if (is_signed && (a == MIN_W) && (b == ONES_W)) begin
                        quo_s   = a;
                        rem_s   = ZERO_W;
                        neg_q_s = 1'b0;
                        neg_r_s = 1'b0;
                        state_s = ST_FIX;
                    end else begin
                        quo_s   = magnitude(a, is_signed);
                        rem_s   = ZERO_W;
                        neg_q_s = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_s = is_signed & a[WIDTH-1];
                        state_s = ST_CALC;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_CALC: begin
                if (!trial_s[WIDTH]) begin
                    rem_s = trial_s[WIDTH-1:0];
                    quo_s = {quo_r[WIDTH-2:0], 1'b1};
                end else begin
                    rem_s = shifted_s[WIDTH-1:0];
                    quo_s = {quo_r[WIDTH-2:0], 1'b0};
                end
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_CALC;
                end
            end

            ST_FIX: begin
                if (neg_q_r) begin
                    q_s = negate(quo_r);
                end else begin
                    q_s = quo_r;
                end
                if (neg_r_r) begin
                    r_s = negate(rem_r);
                end else begin
                    r_s = rem_r;
                end
                div0_s  = div0_case_r;
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset abandons any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rem_r       <= ZERO_W;
            quo_r       <= ZERO_W;
            dvs_r       <= ZERO_W;
            cnt_r       <= {CW{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            div0_case_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            q_r         <= ZERO_W;
            r_r         <= ZERO_W;
            div0_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            rem_r       <= rem_s;
            quo_r       <= quo_s;
            dvs_r       <= dvs_s;
            cnt_r       <= cnt_s;
            neg_q_r     <= neg_q_s;
            neg_r_r     <= neg_r_s;
            div0_case_r <= div0_case_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            q_r         <= q_s;
            r_r         <= r_s;
            div0_r      <= div0_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign q    = q_r;
    assign r    = r_r;
    assign div0 = div0_r;

endmodule
